// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: definitions shared by the serial boot loader and its helper
// blocks.
//   state_e                : loader frame-parser states
//   DEFAULT_SYNC_BYTE      : frame start marker
//   DEFAULT_TIMEOUT_CYCLES : idle clocks between bytes before a load aborts
//   csum_add()             : 8-bit modulo-256 checksum accumulate
package ram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_CSUM
    } state_e;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE      = 8'hA5;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1200000;

    function automatic logic [7:0] csum_add(input logic [7:0] acc,
                                            input logic [7:0] data_byte);
        return acc + data_byte;
    endfunction

endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if: byte stream in from the UART receiver plus the RAM write
// port driven by the loader.
//   rx_valid / rx_data      : one-cycle byte strobe and received byte
//   w_en / w_addr / w_data  : RAM write port (one-cycle write pulse)
// Modports:
//   master : the loader (consumes bytes, drives the RAM write port)
//   slave  : the surroundings (UART supplies bytes, RAM takes writes)
interface ram_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
);

    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  w_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;

    modport master (
        input  rx_valid,
        input  rx_data,
        output w_en,
        output w_addr,
        output w_data
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  w_en,
        input  w_addr,
        input  w_data
    );

endinterface

// File: rtl/ram_loader_rx_timeout.sv
// rx_timeout: inactivity down-counter shared by the UART receiver and the
// boot loader.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   clear  : reload the counter (activity seen / not armed); wins over enable
//   enable : count down one per clock
//   expire : high while enabled, not cleared, and the count is exhausted,
//            i.e. CYCLES-1 enabled clocks have passed since the last clear
module rx_timeout #(
    parameter int unsigned CYCLES = 1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned   CW    = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(CYCLES - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = LIMIT;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    // Reset to the full count so an enable straight out of reset cannot
    // fire a spurious expire.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= LIMIT;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && !clear && (count_q == '0);

endmodule

// File: rtl/ram_loader.sv
// ram_loader: serial-to-memory boot loader feeding the program/data RAM.
// Frame: SYNC_BYTE, word count N (0 means 2^ADDR_WIDTH), N words high byte
// first, then an 8-bit modulo-256 checksum of all data bytes.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ram_loader_if.master (rx_valid/rx_data in, w_en/w_addr/w_data out)
//   busy : load in progress, holds the CPU in reset
//   done : one-cycle pulse, frame loaded with matching checksum
//   err  : sticky, checksum mismatch or inter-byte timeout; cleared by sync
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    ram_loader_if.master     bus,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Word counters carry one extra bit so a full 2^ADDR_WIDTH frame can be
    // counted without the address wrapping.
    localparam logic [ADDR_WIDTH:0] FULL_FRAME = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] IDX_ONE    = (ADDR_WIDTH + 1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   total_q, total_d;
    logic [ADDR_WIDTH:0]   idx_q,   idx_d;
    logic [7:0]            hi_q,    hi_d;
    logic [7:0]            csum_q,  csum_d;
    logic                  w_en_q,  w_en_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;
    logic                  err_q,   err_d;

    logic                  to_clear;
    logic                  to_expire;
    logic [ADDR_WIDTH:0]   idx_next;

    // Timer is held loaded while idle and reloaded on every received byte.
    assign to_clear = bus.rx_valid || !busy_q;

    rx_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (to_clear),
        .enable (busy_q),
        .expire (to_expire)
    );

    assign idx_next = idx_q + IDX_ONE;

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        idx_d    = idx_q;
        hi_d     = hi_q;
        csum_d   = csum_q;
        w_en_d   = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        if (bus.rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_d = ST_COUNT;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        csum_d  = '0;
                        idx_d   = '0;
                    end
                end
                ST_COUNT: begin
                    total_d = (bus.rx_data == 8'h00) ? FULL_FRAME
                                                     : (ADDR_WIDTH + 1)'(bus.rx_data);
                    state_d = ST_HI;
                end
                ST_HI: begin
                    hi_d    = bus.rx_data;
                    csum_d  = csum_add(csum_q, bus.rx_data);
                    state_d = ST_LO;
                end
                ST_LO: begin
                    csum_d   = csum_add(csum_q, bus.rx_data);
                    w_en_d   = 1'b1;
                    w_addr_d = idx_q[ADDR_WIDTH-1:0];
                    w_data_d = {hi_q, bus.rx_data};
                    idx_d    = idx_next;
                    state_d  = (idx_next == total_q) ? ST_CSUM : ST_HI;
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (bus.rx_data == csum_q) begin
                        done_d = 1'b1;
                        err_d  = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end else if (to_expire) begin
            // Abort the load; words already written stay in RAM.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            total_q  <= '0;
            idx_q    <= '0;
            hi_q     <= '0;
            csum_q   <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            idx_q    <= idx_d;
            hi_q     <= hi_d;
            csum_q   <= csum_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.w_en   = w_en_q;
    assign bus.w_addr = w_addr_q;
    assign bus.w_data = w_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed self-checking bench for ram_loader.
module tb_ram_loader;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 16;

    logic clk;
    logic rst;
    logic busy;
    logic done;
    logic err;

    int errors;
    int checks;

    // write / event log filled by the monitor
    logic [AW-1:0] log_addr [0:1023];
    logic [DW-1:0] log_data [0:1023];
    int wr_count;
    int done_count;
    int both_count;

    ram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_loader #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.w_en === 1'b1) begin
            if (wr_count < 1024) begin
                log_addr[wr_count] = bus.w_addr;
                log_data[wr_count] = bus.w_data;
            end
            wr_count = wr_count + 1;
        end
        if (done === 1'b1) done_count = done_count + 1;
        if (done === 1'b1 && err === 1'b1) both_count = both_count + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one byte for exactly one clock; returns 1 time unit after the
    // edge that sampled it, so registered responses are visible
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    int base;
    int bad;

    initial begin
        errors     = 0;
        checks     = 0;
        wr_count   = 0;
        done_count = 0;
        both_count = 0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_w_en", 32'(bus.w_en), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err",  32'(err), 32'd0);
        rst = 1'b0;

        // garbage in IDLE is ignored
        send_byte(8'h00);
        check("garbage_00_busy", 32'(busy), 32'd0);
        send_byte(8'hFF);
        check("garbage_ff_busy", 32'(busy), 32'd0);
        send_byte(8'h5A);
        check("garbage_5a_busy", 32'(busy), 32'd0);
        check("garbage_no_write", 32'(wr_count), 32'd0);

        // nominal frame A5,02,12,34,AB,CD,BE
        send_byte(8'hA5);
        check("nom_busy_sync", 32'(busy), 32'd1);
        send_byte(8'h02);
        send_byte(8'h12);
        check("nom_no_wen_on_hi", 32'(bus.w_en), 32'd0);
        send_byte(8'h34);
        check("nom_w0_en",   32'(bus.w_en),   32'd1);
        check("nom_w0_addr", 32'(bus.w_addr), 32'h00);
        check("nom_w0_data", 32'(bus.w_data), 32'h1234);
        tick();
        check("nom_w0_pulse_end", 32'(bus.w_en), 32'd0);
        check("nom_w0_data_hold", 32'(bus.w_data), 32'h1234);
        send_byte(8'hAB);
        send_byte(8'hCD);
        check("nom_w1_en",   32'(bus.w_en),   32'd1);
        check("nom_w1_addr", 32'(bus.w_addr), 32'h01);
        check("nom_w1_data", 32'(bus.w_data), 32'hABCD);
        check("nom_busy_before_csum", 32'(busy), 32'd1);
        send_byte(8'hBE);
        check("nom_done", 32'(done), 32'd1);
        check("nom_err",  32'(err),  32'd0);
        check("nom_busy_fall", 32'(busy), 32'd0);
        tick();
        check("nom_done_pulse_end", 32'(done), 32'd0);
        check("nom_write_count", 32'(wr_count), 32'd2);

        // bad checksum frame ending BF
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hBF);
        check("bad_err",  32'(err),  32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_busy", 32'(busy), 32'd0);
        check("bad_write_count", 32'(wr_count), 32'd4);
        check("bad_w1_data", 32'(log_data[3]), 32'hABCD);
        repeat (5) tick();
        check("bad_err_sticky", 32'(err), 32'd1);

        // next sync clears err; then A5,01,12 and silence -> timeout
        send_byte(8'hA5);
        check("to_sync_clears_err", 32'(err), 32'd0);
        check("to_busy", 32'(busy), 32'd1);
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (TO - 1) tick();
        check("to_busy_before_limit", 32'(busy), 32'd1);
        tick();
        check("to_busy_after_limit", 32'(busy), 32'd0);
        check("to_err", 32'(err), 32'd1);
        check("to_no_write", 32'(wr_count), 32'd4);
        check("to_no_done", 32'(done_count), 32'd1);

        // reset mid-frame after one write
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        check("rstmid_write", 32'(bus.w_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_w_en", 32'(bus.w_en), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_err",  32'(err), 32'd0);
        send_byte(8'hAB);
        send_byte(8'hCD);
        check("rstmid_no_more_writes", 32'(wr_count), 32'd5);
        check("rstmid_idle", 32'(busy), 32'd0);

        // full 256-word frame, one byte every clock; word i = {i,i};
        // checksum = sum of 2*i over 0..255 = 0x00 mod 256
        base = wr_count;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        tick();
        bus.rx_data  = 8'h00;
        for (int i = 0; i < 256; i++) begin
            tick();
            bus.rx_data = i[7:0];
            tick();
            bus.rx_data = i[7:0];
        end
        tick();
        check("full_busy_mid", 32'(busy), 32'd1);
        bus.rx_data = 8'h00;
        tick();
        bus.rx_valid = 1'b0;
        check("full_done", 32'(done), 32'd1);
        check("full_err",  32'(err),  32'd0);
        check("full_busy_fall", 32'(busy), 32'd0);
        tick();
        check("full_write_count", 32'(wr_count - base), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (log_addr[base + i] !== i[7:0]) bad = bad + 1;
            if (log_data[base + i] !== {i[7:0], i[7:0]}) bad = bad + 1;
        end
        check("full_addr_data_order", 32'(bad), 32'd0);
        check("total_done_pulses", 32'(done_count), 32'd2);
        check("done_err_exclusive", 32'(both_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Serial-to-memory boot loader that sits directly upstream of the 256x16 program/data RAM.
- Consumes a byte stream from the UART receiver, framed as: sync byte, word count, 16-bit words (high byte first), then a checksum.
- Drives the RAM write port (w_en, w_addr, w_data) with one write per received word at sequential addresses starting at 0.
- busy holds the CPU in reset while a load is in progress.

Parameters:
- ADDR_WIDTH, 8, RAM address width; max 2^ADDR_WIDTH words per frame.
- DATA_WIDTH, 16, RAM word width; fixed at 2 bytes per word.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1200000, idle clocks between bytes before a load aborts (100 ms at 12 MHz).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  received byte, valid only when rx_valid=1.
- w_en  out  1  RAM write enable, one-cycle pulse.
- w_addr  out  ADDR_WIDTH  RAM write address.
- w_data  out  DATA_WIDTH  RAM write data.
- busy  out  1  load in progress; CPU held in reset.
- done  out  1  one-cycle pulse: frame loaded, checksum matched.
- err  out  1  sticky: checksum mismatch or timeout.

Behaviour:
- Reset: one clock, one reset; reset is synchronous and active-high. All outputs 0, state IDLE, counters 0. RAM contents already written are not touched.
- States:
  - IDLE: rx_valid with rx_data==SYNC_BYTE -> COUNT; busy=1; err cleared; checksum=0. All other bytes ignored.
  - COUNT: next byte latched as N; N=0 means 2^ADDR_WIDTH words. -> HI.
  - HI: byte stored as word[15:8]; added to checksum. -> LO.
  - LO: byte forms word[7:0]; added to checksum; write issued. -> HI if more words remain, else CSUM.
  - CSUM: byte compared with checksum.
    - Match: done pulses for 1 cycle, err=0.
    - Mismatch: err=1.
    - Either case -> IDLE, busy=0.
- Checksum: 8-bit sum, mod 256, of all data bytes. Sync and count bytes are excluded.
- Write timing:
  - w_en=1 for exactly one cycle, the cycle after the rx_valid of the LO byte.
  - w_data={hi,lo}; w_addr=word index, 0..N-1.
  - w_addr and w_data hold their value after the pulse; w_en=0 otherwise.
- Latency: rx_valid (LO) -> w_en is 1 clk. rx_valid (CSUM) -> done/err is 1 clk; busy falls in the same cycle.
- Address:
  - Word index counter is ADDR_WIDTH+1 bits for termination.
  - w_addr never wraps within a frame; N=256 writes 0..255 exactly once.
- Timeout:
  - Counter runs while busy and clears on every rx_valid.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, busy=0, err=1, no done.
  - Words already written remain in RAM.
- rx_valid on consecutive clocks: supported; every byte is consumed, none dropped.
- Sync byte arriving mid-frame: treated as data, no resync. Recovery is via timeout.
- rst mid-frame: immediate return to IDLE; outputs go to reset values on the next edge.
- done and err are never 1 in the same cycle.

Decomposition:
- Shared package / header loader_defs: state encodings (IDLE, COUNT, HI, LO, CSUM) and the SYNC_BYTE default.
- One sub-module, rx_timeout:
  - Parameterised down-counter with clear and enable inputs and an expire pulse output.
  - Reused by the UART receiver and the loader.

Test Plan:
- Reset mid-operation: assert rst for 1 clk during reset or mid-frame -> busy=0, w_en=0, done=0, err=0 the next cycle; no further writes.
- Nominal frame: A5,02,12,34,AB,CD,BE -> writes addr0=16'h1234, addr1=16'hABCD; one w_en pulse each, 1 clk after the LO byte; done pulse after BE; err=0; busy high from A5 until done.
- Bad checksum: same frame ending BF -> both writes occur, err=1 (sticky), no done. A following valid frame clears err on its A5.
- Garbage and timeout:
  - Bytes 00,FF,5A in IDLE -> no state change.
  - A5,01,12 then silence for TIMEOUT_CYCLES (use a small parameter in sim) -> busy=0, err=1, no w_en.
- Full frame, back-to-back: A5,00, 256 words (value = addr*257), correct checksum, rx_valid every clock -> 256 writes at addr 0..255, no drop, no wrap, done asserted.
